// File: rtl/updown_counter_pkg.sv
// Shared constants and count-mode decode for updown_counter.
// Optional modulus feature in the design files: UPDOWN_COUNTER_MOD_EN.
package updown_counter_pkg;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    LOAD = 2'd1,
    INC  = 2'd2,
    DEC  = 2'd3
  } cnt_mode_e;

  // Load beats counting; counting needs both active-low enables asserted.
  function automatic cnt_mode_e cnt_mode(input logic load_n, input logic enb_p_n,
                                         input logic enb_t_n, input logic up_dn);
    if (!load_n)                 return LOAD;
    else if (!enb_p_n && !enb_t_n) return up_dn ? INC : DEC;
    else                         return HOLD;
  endfunction

endpackage

// File: rtl/updown_counter_tc.sv
// Terminal-count compare and active-low ripple carry/borrow for updown_counter.
module updown_counter_tc #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] cnt,
  input  logic [WIDTH-1:0] tc_up,
  input  logic             up_dn,
  input  logic             enb_t_n,
  output logic             at_tc,
  output logic             co_n
);

  assign at_tc = (cnt == (up_dn ? tc_up : '0));
  // Only ENB_T gates the carry so a chained stage sees it before its own count edge.
  assign co_n  = ~(at_tc & ~enb_t_n);

endmodule

// File: rtl/updown_counter.sv
// Loadable up/down counter with cascadable ripple carry.
// Define UPDOWN_COUNTER_MOD_EN to add the LIMIT port and modulo-(LIMIT+1) counting.
import updown_counter_pkg::*;

module updown_counter #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [WIDTH-1:0] I,
  input  logic             LOAD_N,
  input  logic             ENB_P_N,
  input  logic             ENB_T_N,
  input  logic             UP_DN,
`ifdef UPDOWN_COUNTER_MOD_EN
  input  logic [WIDTH-1:0] LIMIT,
`endif
  output logic [WIDTH-1:0] O,
  output logic             CO_N
);

  logic [WIDTH-1:0] lim;
  logic [WIDTH-1:0] cnt_nxt;
  logic             at_tc;
  cnt_mode_e        mode;

`ifdef UPDOWN_COUNTER_MOD_EN
  assign lim = LIMIT;
`else
  assign lim = '1;
`endif

  assign mode = cnt_mode(LOAD_N, ENB_P_N, ENB_T_N, UP_DN);

  // at_tc tracks UP_DN, so in INC it means O==lim and in DEC it means O==0.
  // A value above lim never matches, so it free-runs to max and wraps naturally.
  always_comb begin
    cnt_nxt = O;
    unique case (mode)
      LOAD:    cnt_nxt = I;
      INC:     cnt_nxt = at_tc ? '0  : O + 1'b1;
      DEC:     cnt_nxt = at_tc ? lim : O - 1'b1;
      default: cnt_nxt = O;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) O <= '0;
    else          O <= cnt_nxt;
  end

  updown_counter_tc #(.WIDTH(WIDTH)) u_tc (
    .cnt     (O),
    .tc_up   (lim),
    .up_dn   (UP_DN),
    .enb_t_n (ENB_T_N),
    .at_tc   (at_tc),
    .co_n    (CO_N)
  );

endmodule

// File: tb/tb_updown_counter.sv
// Scoreboard bench: single 4-bit counter plus a two-stage 8-bit cascade.
module tb_updown_counter;

  localparam int W = 4;

  typedef struct {
    int   o;
    logic co;
    int   c;
    logic cco;
  } exp_t;

  logic         CLK = 1'b0;
  logic         RESET_N = 1'b0;
  logic [W-1:0] I = '0;
  logic         LOAD_N = 1'b1, ENB_P_N = 1'b1, ENB_T_N = 1'b1, UP_DN = 1'b1;
  logic [W-1:0] O;
  logic         CO_N;
  logic [7:0]   CI = '0;
  logic [W-1:0] o0, o1;
  logic         co0, co1;
`ifdef UPDOWN_COUNTER_MOD_EN
  logic [W-1:0] LIMIT = 4'hF;
  logic [W-1:0] LIM_F = 4'hF;
`endif

  int   checks = 0;
  int   errors = 0;
  int   m = 0;
  int   c = 0;
  bit   drv_done = 0;
  exp_t exp_q[$];

  always #5 CLK = ~CLK;

  updown_counter #(.WIDTH(W)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .I(I), .LOAD_N(LOAD_N), .ENB_P_N(ENB_P_N),
    .ENB_T_N(ENB_T_N), .UP_DN(UP_DN),
`ifdef UPDOWN_COUNTER_MOD_EN
    .LIMIT(LIMIT),
`endif
    .O(O), .CO_N(CO_N));

  updown_counter #(.WIDTH(W)) cas0 (
    .CLK(CLK), .RESET_N(RESET_N), .I(CI[3:0]), .LOAD_N(LOAD_N), .ENB_P_N(ENB_P_N),
    .ENB_T_N(ENB_T_N), .UP_DN(UP_DN),
`ifdef UPDOWN_COUNTER_MOD_EN
    .LIMIT(LIM_F),
`endif
    .O(o0), .CO_N(co0));

  updown_counter #(.WIDTH(W)) cas1 (
    .CLK(CLK), .RESET_N(RESET_N), .I(CI[7:4]), .LOAD_N(LOAD_N), .ENB_P_N(ENB_P_N),
    .ENB_T_N(co0), .UP_DN(UP_DN),
`ifdef UPDOWN_COUNTER_MOD_EN
    .LIMIT(LIM_F),
`endif
    .O(o1), .CO_N(co1));

  function automatic int cur_lim();
`ifdef UPDOWN_COUNTER_MOD_EN
    return int'(LIMIT);
`else
    return (1 << W) - 1;
`endif
  endfunction

  // Counting within 0..lim is modulo lim+1; a loaded value above lim counts mod 2^W.
  function automatic int model_next(int v, logic up, int lim);
    int full = 1 << W;
    if (up) return (v <= lim) ? (v + 1) % (lim + 1) : (v + 1) % full;
    else    return (v <= lim) ? (v + lim) % (lim + 1) : v - 1;
  endfunction

  // Apply one cycle: model the edge just taken with the held inputs, then drive new ones.
  task automatic step(input logic rst, input logic ld, input int d, input int cd,
                      input logic ep, input logic et, input logic ud);
    exp_t e;
    int   lim;
    @(posedge CLK); #1;
    lim = cur_lim();
    if (!RESET_N) begin
      m = 0; c = 0;
    end else if (!LOAD_N) begin
      m = int'(I); c = int'(CI);
    end else if (!ENB_P_N && !ENB_T_N) begin
      m = model_next(m, UP_DN, lim);
      c = UP_DN ? (c + 1) % 256 : (c + 255) % 256;
    end
    RESET_N = rst; LOAD_N = ld; I = d[W-1:0]; CI = cd[7:0];
    ENB_P_N = ep; ENB_T_N = et; UP_DN = ud;
    if (!rst) begin
      m = 0; c = 0;
    end
    lim   = cur_lim();
    e.o   = m;
    e.co  = !((m == (ud ? lim : 0)) && !et);
    e.c   = c;
    e.cco = !((c == (ud ? 255 : 0)) && !et);
    #1 exp_q.push_back(e);
  endtask

  task automatic cmp(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp("o",        int'(O),          e.o);
        cmp("co_n",     int'(CO_N),       int'(e.co));
        cmp("cascade",  int'({o1, o0}),   e.c);
        cmp("cas_co_n", int'(co1),        int'(e.cco));
      end
    end
  end

  initial begin : driver
    // reset held, down with ENB_T asserted -> CO_N low at O=0
    step(0, 1, 0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 1, 0, 0);
    step(1, 0, 9, 8'h09, 1, 1, 1);
    step(1, 1, 0, 0, 1, 1, 1);
    // async reset between edges from O=9
    step(0, 1, 0, 0, 1, 0, 0);
    step(1, 0, 5, 8'h05, 1, 1, 1);
    step(1, 0, 7, 8'h07, 0, 0, 0);
    // reset together with a pending load aborts the load
    step(0, 0, 3, 8'h33, 1, 1, 1);
    // wrap up through 15 and down through 0
    step(1, 0, 14, 8'h0E, 1, 1, 1);
    step(1, 1, 0, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    // enable gating at 15
    step(1, 0, 15, 8'h0F, 1, 1, 1);
    step(1, 1, 0, 0, 1, 0, 1);
    step(1, 1, 0, 0, 1, 1, 1);
    // cascade 0x0F -> 0x10 -> 0x0F, with direction flip
    step(1, 0, 15, 8'h0F, 1, 1, 1);
    step(1, 1, 0, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 1, 1, 0);
`ifdef UPDOWN_COUNTER_MOD_EN
    LIMIT = 4'd9;
    step(1, 0, 8, 8'h08, 1, 1, 1);
    step(1, 1, 0, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    step(1, 0, 12, 8'hC0, 1, 1, 1);
    for (int k = 0; k < 5; k++) step(1, 1, 0, 0, 0, 0, 1);
`endif
    for (int k = 0; k < 400; k++) begin
`ifdef UPDOWN_COUNTER_MOD_EN
      if ($urandom_range(0, 15) == 0) LIMIT = W'($urandom_range(1, 15));
`endif
      step($urandom_range(0, 40) != 0, $urandom_range(0, 9) != 0,
           int'($urandom_range(0, 15)), int'($urandom_range(0, 255)),
           $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 3) != 0);
    end
    drv_done = 1;
  end

  initial begin : finisher
    int budget;
    wait (drv_done);
    budget = 0;
    while (exp_q.size() > 0 && budget < 20) begin
      @(negedge CLK); #1;
      budget++;
    end
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain actual=%0d pending required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $finish;
  end

endmodule
